goodie_collector: RTL and testbench



---
 rtl/goodie_collector.sv | 120 ++++++++++++
 tb/tb_goodie_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/goodie_collector.sv
// Goodie collector: AABB hit test on frame_tick, collection pulses, saturating score, hide timer.
// Latency: overlap tick -> collect_pulse/goodie_init 1 cycle; score updates on the cycle after the pulse.
// No backpressure; optional combo bonus compiled in with `define GOODIE_COMBO_EN.
module goodie_collector #(
  parameter int PLAYER_W    = 40,
  parameter int PLAYER_H    = 30,
  parameter int GOODIE_W    = 20,
  parameter int GOODIE_H    = 20,
  parameter int SCREEN_W    = 1280,
  parameter int SCREEN_H    = 1024,
  parameter int HOLD_FRAMES = 30,
  parameter int SCORE_MAX   = 255
) (
  input  logic        clk,
  input  logic        initialize,
  input  logic        frame_tick,
  input  logic [10:0] player_x,
  input  logic [9:0]  player_y,
  input  logic [10:0] goodie_x,
  input  logic [9:0]  goodie_y,
  output logic        goodie_init,
  output logic        collect_pulse,
  output logic [7:0]  score,
  output logic        goodie_visible
);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    HIT    = 2'd1,
    HIDDEN = 2'd2
  } state_t;

  localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [11:0] PW        = 12'(PLAYER_W);
  localparam logic [11:0] PH        = 12'(PLAYER_H);
  localparam logic [11:0] GW        = 12'(GOODIE_W);
  localparam logic [11:0] GH        = 12'(GOODIE_H);
  localparam logic [11:0] SW        = 12'(SCREEN_W);
  localparam logic [11:0] SH        = 12'(SCREEN_H);
  localparam logic [8:0]  SCORE_LIM = 9'(SCORE_MAX);
  localparam logic [7:0]  SCORE_CAP = 8'(SCORE_MAX);

  state_t          state;
  state_t          state_nxt;
  logic [HC_W-1:0] hide_cnt;
  logic [11:0]     px, py, gx, gy;
  logic            overlap;
  logic [1:0]      inc;
  logic [8:0]      score_sum;
  logic [7:0]      score_sat;

  // 12-bit operands so no sum can wrap; off-screen goodie coordinates never collide.
  assign px = {1'b0, player_x};
  assign py = {2'b00, player_y};
  assign gx = {1'b0, goodie_x};
  assign gy = {2'b00, goodie_y};

  assign overlap = (px < gx + GW) && (gx < px + PW) &&
                   (py < gy + GH) && (gy < py + PH) &&
                   (gx < SW) && (gy < SH);

`ifdef GOODIE_COMBO_EN
  logic [7:0] combo_cnt;

  always_ff @(posedge clk) begin
    if (initialize) begin
      combo_cnt <= 8'd0;
    end else if (state == HIT) begin
      combo_cnt <= 8'd120;
    end else if (frame_tick && (combo_cnt != 8'd0)) begin
      combo_cnt <= combo_cnt - 8'd1;
    end
  end

  assign inc = (combo_cnt != 8'd0) ? 2'd2 : 2'd1;
`else
  assign inc = 2'd1;
`endif

  assign score_sum = {1'b0, score} + {7'd0, inc};
  assign score_sat = (score_sum > SCORE_LIM) ? SCORE_CAP : score_sum[7:0];

  always_ff @(posedge clk) begin
    if (initialize) begin
      state <= TRACK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TRACK:   if (frame_tick && overlap) state_nxt = HIT;
      HIT:     state_nxt = (HOLD_FRAMES == 0) ? TRACK : HIDDEN;
      HIDDEN:  if (frame_tick && (hide_cnt <= HC_W'(1))) state_nxt = TRACK;
      default: state_nxt = TRACK;
    endcase
  end

  always_comb begin
    collect_pulse  = (state == HIT);
    goodie_init    = (state == HIT);
    goodie_visible = (state == TRACK);
  end

  always_ff @(posedge clk) begin
    if (initialize) begin
      score    <= 8'd0;
      hide_cnt <= '0;
    end else if (state == HIT) begin
      score    <= score_sat;
      hide_cnt <= HC_W'(HOLD_FRAMES);
    end else if ((state == HIDDEN) && frame_tick && (hide_cnt != '0)) begin
      hide_cnt <= hide_cnt - HC_W'(1);
    end
  end

endmodule

// File: tb/tb_goodie_collector.sv
// Scoreboard bench for goodie_collector: directed scenarios plus randomized play against a reference model.
module tb_goodie_collector;

  localparam int HOLD = 30;
`ifdef GOODIE_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        initialize = 1'b1;
  logic        frame_tick = 1'b0;
  logic [10:0] player_x = '0;
  logic [9:0]  player_y = '0;
  logic [10:0] goodie_x = '0;
  logic [9:0]  goodie_y = '0;
  logic        goodie_init;
  logic        collect_pulse;
  logic [7:0]  score;
  logic        goodie_visible;

  goodie_collector #(
    .PLAYER_W(40), .PLAYER_H(30), .GOODIE_W(20), .GOODIE_H(20),
    .SCREEN_W(1280), .SCREEN_H(1024), .HOLD_FRAMES(HOLD), .SCORE_MAX(255)
  ) dut (
    .clk(clk),
    .initialize(initialize),
    .frame_tick(frame_tick),
    .player_x(player_x),
    .player_y(player_y),
    .goodie_x(goodie_x),
    .goodie_y(goodie_y),
    .goodie_init(goodie_init),
    .collect_pulse(collect_pulse),
    .score(score),
    .goodie_visible(goodie_visible)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit pulse;
    bit vis;
    int score;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: visibility, pending collection, frames left hidden, ticks since last collection.
  bit m_pending = 1'b0;
  bit m_vis = 1'b1;
  int m_score = 0;
  int m_hold = 0;
  int m_since = 1000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hits(input int px, input int py, input int gx, input int gy);
    if (gx >= 1280 || gy >= 1024) return 1'b0;
    return (px < gx + 20) && (gx < px + 40) && (py < gy + 20) && (gy < py + 30);
  endfunction

  // Drive one cycle at a negedge, queue the expected post-edge outputs, return at the next negedge.
  task automatic step(input bit init, input bit tick, input int px, input int py,
                      input int gx, input int gy);
    exp_t e;
    int   bonus;
    initialize = init;
    frame_tick = tick;
    player_x   = 11'(px);
    player_y   = 10'(py);
    goodie_x   = 11'(gx);
    goodie_y   = 10'(gy);
    if (init) begin
      m_pending = 1'b0; m_vis = 1'b1; m_score = 0; m_hold = 0; m_since = 1000;
    end else if (m_pending) begin
      bonus     = (COMBO && m_since < 120) ? 2 : 1;
      m_score   = (m_score + bonus > 255) ? 255 : m_score + bonus;
      m_pending = 1'b0;
      m_since   = 0;
      m_hold    = HOLD;
      m_vis     = (HOLD == 0);
    end else begin
      if (tick) m_since++;
      if (m_vis && tick && hits(px, py, gx, gy)) begin
        m_pending = 1'b1;
        m_vis     = 1'b0;
      end else if (!m_vis && tick) begin
        m_hold--;
        if (m_hold == 0) m_vis = 1'b1;
      end
    end
    e.pulse = m_pending;
    e.vis   = m_vis;
    e.score = m_score;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Collect once at an overlapping position, then sit out the whole hide period.
  task automatic collect_and_wait();
    step(0, 1, 100, 100, 110, 110);
    step(0, 0, 100, 100, 110, 110);
    for (int i = 0; i < HOLD; i++) step(0, 1, 100, 100, 110, 110);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_collect_pulse", int'(collect_pulse), int'(e.pulse));
      chk("sb_goodie_init", int'(goodie_init), int'(e.pulse));
      chk("sb_goodie_visible", int'(goodie_visible), int'(e.vis));
      chk("sb_score", int'(score), e.score);
    end
  end

  initial begin
    int px, py, gx, gy;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_score", int'(score), 0);
    chk("reset_visible", int'(goodie_visible), 1);
    chk("reset_pulse", int'(collect_pulse), 0);
    chk("reset_init", int'(goodie_init), 0);

    step(0, 1, 100, 100, 110, 110);
    chk("hit_pulse", int'(collect_pulse), 1);
    chk("hit_init", int'(goodie_init), 1);
    chk("hit_visible", int'(goodie_visible), 0);
    step(0, 0, 100, 100, 110, 110);
    chk("after_hit_pulse", int'(collect_pulse), 0);
    chk("after_hit_score", int'(score), 1);
    chk("after_hit_visible", int'(goodie_visible), 0);

    for (int i = 1; i <= HOLD; i++) begin
      step(0, 1, 100, 100, 110, 110);
      chk("hidden_no_pulse", int'(collect_pulse), 0);
      if (i < HOLD) chk("hidden_invisible", int'(goodie_visible), 0);
    end
    chk("hold_end_visible", int'(goodie_visible), 1);
    step(0, 1, 100, 100, 110, 110);
    chk("second_hit_pulse", int'(collect_pulse), 1);
    step(0, 0, 100, 100, 110, 110);
    chk("second_hit_score", int'(score), COMBO ? 3 : 2);

    for (int i = 0; i < HOLD; i++) step(0, 1, 0, 0, 500, 500);
    step(0, 1, 100, 100, 140, 100);
    chk("edge_x_no_hit", int'(collect_pulse), 0);
    step(0, 1, 100, 100, 100, 130);
    chk("edge_y_no_hit", int'(collect_pulse), 0);
    step(0, 1, 2030, 100, 2045, 110);
    chk("wrapped_no_hit", int'(collect_pulse), 0);
    step(0, 1, 100, 100, 139, 129);
    chk("corner_hit", int'(collect_pulse), 1);
    step(0, 0, 0, 0, 500, 500);
    for (int i = 0; i < HOLD; i++) step(0, 1, 0, 0, 500, 500);

    while (m_score < 255) collect_and_wait();
    chk("saturated_score", int'(score), 255);
    step(0, 1, 100, 100, 110, 110);
    chk("sat_hit_pulse", int'(collect_pulse), 1);
    chk("sat_hit_init", int'(goodie_init), 1);
    step(0, 0, 100, 100, 110, 110);
    chk("sat_score_held", int'(score), 255);
    step(0, 1, 100, 100, 110, 110);
    step(1, 1, 100, 100, 110, 110);
    chk("abort_hidden_visible", int'(goodie_visible), 1);
    chk("abort_hidden_score", int'(score), 0);
    chk("abort_hidden_pulse", int'(collect_pulse), 0);

    for (int n = 0; n < 4000; n++) begin
      px = int'($urandom_range(0, 1300));
      py = int'($urandom_range(0, 1023));
      gx = (px + int'($urandom_range(0, 100)) - 50) & 2047;
      gy = (py + int'($urandom_range(0, 100)) - 50) & 1023;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), px, py, gx, gy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
